pe_array_os_tile: RTL and testbench
===================================

// Module: pe_array_os_tile
// PURPOSE
//  Parametrised output-stationary systolic tile: ROW_len x COL_len MAC array with built-in input skew,
//  a K-depth tile controller FSM, optional saturation and valid/ready row-wise result drain.
//  Sits between the operand buffers (A column-vectors, B row-vectors per beat) and the result writeback.
//  One start = one C[ROW_len][COL_len] = A[ROW_len][K] x B[K][COL_len] tile; accumulators clear on start.
// PARAMETERS
//  ROW_len    3   array rows (A channels), >=1
//  COL_len    3   array columns (B channels / c_bus lanes), >=1
//  DW         8   signed A/B operand width
//  ACCW       16  signed accumulator / result width, ACCW >= 2*DW
//  KW         16  width of k_len
//  SAT        0   1: saturating accumulate; 0: two's-complement wrap
//  DRAIN_DESC 1   1: drain rows ROW_len-1 down to 0; 0: rows 0 up to ROW_len-1
// PORTS
//  clk       in   1            clock, all state on rising edge
//  rst_n     in   1            asynchronous active-low reset
//  start     in   1            tile request, accepted only in IDLE
//  k_len     in   KW           reduction depth K, sampled with accepted start
//  busy      out  1            high in every state except IDLE
//  in_valid  in   1            a_bus/b_bus beat valid
//  in_ready  out  1            high only in LOAD
//  a_bus     in   ROW_len*DW   A[i][k] at bits [(i+1)*DW-1 -: DW]
//  b_bus     in   COL_len*DW   B[k][j] at bits [(j+1)*DW-1 -: DW]
//  c_valid   out  1            result row valid
//  c_ready   in   1            consumer accepts row
//  c_bus     out  COL_len*ACCW C[row][j] at bits [(j+1)*ACCW-1 -: ACCW]
//  c_row     out  $clog2(ROW_len) (min 1)  row index of c_bus
//  done      out  1            one-cycle pulse after last row handshake
// BEHAVIOUR
//  Reset: FSM=IDLE; all accumulators, skew and PE pipeline regs 0; busy/in_ready/c_valid/done=0; c_bus=0; c_row=0.
//  FSM: IDLE -start-> LOAD (k_len!=0) or DRAIN (k_len==0, all-zero results); LOAD -K beats-> FLUSH;
//       FLUSH -ROW_len+COL_len-1 cycles-> DRAIN; DRAIN -last row accepted-> IDLE with done=1 for that cycle.
//  Accepted start synchronously clears all accumulators and skew regs; LOAD is entered the next cycle.
//  start while busy is ignored (no queuing). k_len is latched; later changes have no effect.
//  LOAD: beat transfers on in_valid&in_ready; beat counter counts 0..K-1. Array step enable = transfer.
//    in_valid=0 stalls the whole array (skew regs, PE a/b regs, accumulators hold) - gaps never corrupt results.
//  Skew: A lane i delayed i stages, B lane j delayed j stages, all advancing only on array step enable.
//  PE(i,j): when enabled, acc += a_in*b_in (2*DW signed product, sign-extended to ACCW); a/b forwarded right/down
//    through one register each. FLUSH steps the array every cycle with zero inputs to retire in-flight operands.
//  SAT=1: acc clamps to [-2^(ACCW-1), 2^(ACCW-1)-1] and stays clamped; SAT=0: wraps modulo 2^ACCW.
//  DRAIN: first row registered on DRAIN entry; c_valid=1 the cycle after entry. c_bus/c_row stable while
//    c_valid&!c_ready. On c_valid&c_ready next row presented the following cycle (no bubble); after last row
//    c_valid drops, done pulses. Row order per DRAIN_DESC. Accumulators hold their values until next start.
//  Latency (no stalls): start accepted cycle t -> first c_valid at t+1+K+ROW_len+COL_len.
//  Reset mid-operation: immediate return to reset state; a partial tile is discarded, no done.
// STRUCTURE
//  Shared package sa_pkg: DW/ACCW defaults, FSM state encoding (IDLE,LOAD,FLUSH,DRAIN), sat_add function.
//  One sub-module: pe_mac_os (step enable, sync clear, SAT param, a/b forward regs, acc out).
//  Top holds skew shift regs, beat/flush/row counters, FSM and drain mux/register.
// TESTING
//  1. 3x3, SAT=0, K=3, A=I, B=[1..9] row-major, no stalls -> rows out 2,1,0 = {7,8,9},{4,5,6},{1,2,3}; done once.
//  2. Same tile with in_valid low for 2 cycles after beats 0 and 1 -> identical results; latency grows by 4.
//  3. 2x2, DW=8, ACCW=16, K=4, all operands -128, SAT=1 -> every C=32767 (4*16384 clamped); SAT=0 -> -1*? wrap = 0x0000.
//  4. DRAIN_DESC=0, c_ready low for 5 cycles on row 1 -> c_bus/c_row frozen, rows 0,1,2 in order, no duplicates.
//  5. k_len=0 start -> in_ready never asserts; three all-zero rows drained; start during DRAIN ignored.
//  6. rst_n low mid-LOAD (beat 2 of 4) -> all outputs 0, IDLE; fresh tile after release gives correct C.

Source files
------------

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types, defaults and saturating add for the systolic tile
package sa_pkg;

    localparam int DW_DEF   = 8;
    localparam int ACCW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN
    } tile_state_e;

    // Adds in 64 bits and clamps to the signed range of a w-bit result (w <= 62).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)
            sat_add = hi;
        else if (s < lo)
            sat_add = lo;
        else
            sat_add = s;
    endfunction

endpackage

// File: rtl/pe_mac_os.sv
// rtl/pe_mac_os.sv - output-stationary MAC cell with a/b forwarding registers
module pe_mac_os
    import sa_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF,
    parameter int SAT  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic signed [DW-1:0]   a_in,
    input  logic signed [DW-1:0]   b_in,
    output logic signed [DW-1:0]   a_out,
    output logic signed [DW-1:0]   b_out,
    output logic signed [ACCW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] acc_nxt;

    assign prod     = a_in * b_in;
    assign prod_ext = ACCW'(prod);

    always_comb begin
        acc_nxt = acc + prod_ext;
        if (SAT != 0)
            acc_nxt = ACCW'(sat_add(64'(acc), 64'(prod_ext), ACCW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (clr) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (en) begin
            acc   <= acc_nxt;
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/pe_array_os_tile.sv
// rtl/pe_array_os_tile.sv - output-stationary systolic tile with skew, tile FSM and row drain
module pe_array_os_tile
    import sa_pkg::*;
#(
    parameter int ROW_len    = 3,
    parameter int COL_len    = 3,
    parameter int DW         = DW_DEF,
    parameter int ACCW       = ACCW_DEF,
    parameter int KW         = 16,
    parameter int SAT        = 0,
    parameter int DRAIN_DESC = 1,
    localparam int RW        = (ROW_len > 1) ? $clog2(ROW_len) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROW_len*DW-1:0]     a_bus,
    input  logic [COL_len*DW-1:0]     b_bus,
    output logic                      c_valid,
    input  logic                      c_ready,
    output logic [COL_len*ACCW-1:0]   c_bus,
    output logic [RW-1:0]             c_row,
    output logic                      done
);

    localparam int FW         = $clog2(ROW_len + COL_len);
    localparam int FLUSH_LAST = ROW_len + COL_len - 2;
    localparam int FIRST_ROW  = (DRAIN_DESC != 0) ? ROW_len - 1 : 0;
    localparam int LAST_ROW   = (DRAIN_DESC != 0) ? 0 : ROW_len - 1;

    tile_state_e state;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          step;
    logic          clr;
    logic          load_phase;

    logic signed [DW-1:0]   a_h [ROW_len][COL_len+1];
    logic signed [DW-1:0]   b_v [ROW_len+1][COL_len];
    logic signed [ACCW-1:0] acc [ROW_len][COL_len];

    logic [RW-1:0]           sel_row;
    logic [COL_len*ACCW-1:0] row_data;

    assign load_phase = (state == ST_LOAD);
    assign clr        = start && (state == ST_IDLE);
    assign step       = (load_phase && in_valid) || (state == ST_FLUSH);
    assign busy       = (state != ST_IDLE);
    assign in_ready   = load_phase;

    // Operands outside LOAD are forced to zero so FLUSH retires in-flight data without adding to C.
    for (genvar i = 0; i < ROW_len; i++) begin : g_askew
        logic signed [DW-1:0] src;
        assign src = load_phase ? a_bus[(i+1)*DW-1 -: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_h[i][0] = src;
        end else begin : g_dly
            logic signed [DW-1:0] sr [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || clr) begin
                    for (int s = 0; s < i; s++) sr[s] <= '0;
                end else if (step) begin
                    sr[0] <= src;
                    for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
                end
            end
            assign a_h[i][0] = sr[i-1];
        end
    end

    for (genvar j = 0; j < COL_len; j++) begin : g_bskew
        logic signed [DW-1:0] src;
        assign src = load_phase ? b_bus[(j+1)*DW-1 -: DW] : '0;
        if (j == 0) begin : g_direct
            assign b_v[0][j] = src;
        end else begin : g_dly
            logic signed [DW-1:0] sr [j];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || clr) begin
                    for (int s = 0; s < j; s++) sr[s] <= '0;
                end else if (step) begin
                    sr[0] <= src;
                    for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
                end
            end
            assign b_v[0][j] = sr[j-1];
        end
    end

    for (genvar i = 0; i < ROW_len; i++) begin : g_row
        for (genvar j = 0; j < COL_len; j++) begin : g_col
            pe_mac_os #(
                .DW   (DW),
                .ACCW (ACCW),
                .SAT  (SAT)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (step),
                .clr   (clr),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (acc[i][j])
            );
        end
    end

    // Next row to present: the first row on DRAIN entry, otherwise the neighbour of c_row.
    always_comb begin
        sel_row = RW'(FIRST_ROW);
        if (c_valid)
            sel_row = (DRAIN_DESC != 0) ? c_row - RW'(1) : c_row + RW'(1);
        row_data = '0;
        for (int r = 0; r < ROW_len; r++) begin
            if (sel_row == RW'(r)) begin
                for (int j = 0; j < COL_len; j++)
                    row_data[j*ACCW +: ACCW] = acc[r][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            c_valid   <= 1'b0;
            c_bus     <= '0;
            c_row     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_reg     <= k_len;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                        state     <= (k_len == '0) ? ST_DRAIN : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt == k_reg - KW'(1))
                            state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FW'(FLUSH_LAST))
                        state <= ST_DRAIN;
                    else
                        flush_cnt <= flush_cnt + FW'(1);
                end
                ST_DRAIN: begin
                    if (!c_valid) begin
                        c_valid <= 1'b1;
                        c_row   <= sel_row;
                        c_bus   <= row_data;
                    end else if (c_ready) begin
                        if (c_row == RW'(LAST_ROW)) begin
                            c_valid <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            c_row <= sel_row;
                            c_bus <= row_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_array_os_tile.sv
// tb/tb_pe_array_os_tile.sv - self-checking bench for pe_array_os_tile against a matrix-product model
module tb_pe_array_os_tile;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_s    [4];
    logic        in_valid_s [4];
    logic        c_ready_s  [4];
    logic [15:0] k_len_s    [4];
    logic [23:0] a_s        [4];
    logic [23:0] b_s        [4];
    logic        busy_s     [4];
    logic        in_ready_s [4];
    logic        c_valid_s  [4];
    logic        done_s     [4];
    logic [47:0] c_bus_s    [4];
    logic [1:0]  c_row_s    [4];

    int A_m [3][16];
    int B_m [16][3];
    int gap_after [16];
    int n_chk = 0;
    int n_fail = 0;

    // Instance 0: 3x3 wrap desc, 1: 2x2 sat desc, 2: 3x3 wrap asc, 3: 2x2 wrap asc
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int R  = (g == 1 || g == 3) ? 2 : 3;
        localparam int RB = (R > 1) ? $clog2(R) : 1;
        logic [R*16-1:0] cb;
        logic [RB-1:0]   cr;
        pe_array_os_tile #(
            .ROW_len    (R),
            .COL_len    (R),
            .DW         (8),
            .ACCW       (16),
            .KW         (16),
            .SAT        ((g == 1) ? 1 : 0),
            .DRAIN_DESC ((g < 2) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_s[g]),
            .k_len    (k_len_s[g]),
            .busy     (busy_s[g]),
            .in_valid (in_valid_s[g]),
            .in_ready (in_ready_s[g]),
            .a_bus    (a_s[g][R*8-1:0]),
            .b_bus    (b_s[g][R*8-1:0]),
            .c_valid  (c_valid_s[g]),
            .c_ready  (c_ready_s[g]),
            .c_bus    (cb),
            .c_row    (cr),
            .done     (done_s[g])
        );
        assign c_bus_s[g] = 48'(cb);
        assign c_row_s[g] = 2'(cr);
    end

    function automatic int rows_of(input int d);
        return (d == 1 || d == 3) ? 2 : 3;
    endfunction

    function automatic bit sat_of(input int d);
        return d == 1;
    endfunction

    function automatic bit desc_of(input int d);
        return d < 2;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 16; k++) begin
            gap_after[k] = 0;
            for (int i = 0; i < 3; i++) A_m[i][k] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < 3; j++) B_m[k][j] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic run_tile(input int d, input int K, input int hold_row, input int hold_cyc,
                            input bit start_in_drain, input string tag);
        int R, beat, gap, rows, n, lat, exp_lat, hold, extra, r_id, acc;
        int expC [3][3];
        bit last_hs, fin;
        logic [15:0] got, expv;
        R = rows_of(d); beat = 0; gap = 0; rows = 0; n = 1; lat = -1;
        hold = hold_cyc; extra = 0; last_hs = 0; fin = 0;
        for (int i = 0; i < R; i++) begin
            for (int j = 0; j < R; j++) begin
                acc = 0;
                for (int k = 0; k < K; k++) begin
                    acc += A_m[i][k] * B_m[k][j];
                    if (sat_of(d)) acc = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
                end
                expC[i][j] = acc;
            end
        end
        exp_lat = (K == 0) ? 2 : 1 + K + 2 * R;
        for (int k = 0; k < K - 1; k++) exp_lat += gap_after[k];

        @(negedge clk);
        start_s[d] = 1'b1; k_len_s[d] = 16'(K); in_valid_s[d] = 1'b0; c_ready_s[d] = 1'b1;
        @(negedge clk);
        k_len_s[d] = 16'($urandom_range(1, 15));
        while (!fin && n < 300) begin
            start_s[d] = 1'b0;
            n_chk++;
            if (done_s[d] !== last_hs) begin
                n_fail++;
                $display("FAIL %s done n=%0d got=%b exp=%b", tag, n, done_s[d], last_hs);
            end
            n_chk++;
            if (busy_s[d] !== !last_hs) begin
                n_fail++;
                $display("FAIL %s busy n=%0d got=%b exp=%b", tag, n, busy_s[d], !last_hs);
            end
            fin = last_hs;
            if (gap > 0) begin
                in_valid_s[d] = 1'b0;
                gap--;
            end else begin
                in_valid_s[d] = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (beat < K) a_s[d][i*8 +: 8] = 8'(A_m[i][beat]);
                    else          a_s[d][i*8 +: 8] = 8'($urandom);
                    if (beat < K) b_s[d][i*8 +: 8] = 8'(B_m[beat][i]);
                    else          b_s[d][i*8 +: 8] = 8'($urandom);
                end
                if (in_ready_s[d]) begin
                    if (beat >= K) extra++;
                    else begin
                        gap = gap_after[beat];
                        beat++;
                    end
                end
            end
            if (c_valid_s[d]) begin
                if (lat < 0) lat = n;
                if (rows >= R) begin
                    n_chk++; n_fail++;
                    $display("FAIL %s extra_row n=%0d got_row=%0d exp=none", tag, n, c_row_s[d]);
                end else begin
                    r_id = desc_of(d) ? R - 1 - rows : rows;
                    n_chk++;
                    if (c_row_s[d] !== 2'(r_id)) begin
                        n_fail++;
                        $display("FAIL %s c_row n=%0d got=%0d exp=%0d", tag, n, c_row_s[d], r_id);
                    end
                    for (int j = 0; j < R; j++) begin
                        got = c_bus_s[d][j*16 +: 16];
                        expv = 16'(expC[r_id][j]);
                        n_chk++;
                        if (got !== expv) begin
                            n_fail++;
                            $display("FAIL %s c_bus row=%0d col=%0d got=%h exp=%h", tag, r_id, j, got, expv);
                        end
                    end
                end
            end
            if (c_valid_s[d] && rows == hold_row && hold > 0) begin
                c_ready_s[d] = 1'b0;
                hold--;
            end else begin
                c_ready_s[d] = 1'b1;
            end
            if (c_valid_s[d] && c_ready_s[d] && rows < R) begin
                rows++;
                if (rows == R) last_hs = 1'b1;
            end
            if (start_in_drain && c_valid_s[d]) start_s[d] = 1'b1;
            @(negedge clk);
            n++;
        end
        start_s[d] = 1'b0;
        in_valid_s[d] = 1'b0;
        n_chk++;
        if (!fin) begin
            n_fail++;
            $display("FAIL %s timeout rows=%0d exp=%0d", tag, rows, R);
        end
        n_chk++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_lat);
        end
        n_chk++;
        if (beat !== K || extra !== 0) begin
            n_fail++;
            $display("FAIL %s beats got=%0d extra_ready=%0d exp=%0d/0", tag, beat, extra, K);
        end
        repeat (3) begin
            n_chk++;
            if (busy_s[d] || c_valid_s[d] || done_s[d] || in_ready_s[d]) begin
                n_fail++;
                $display("FAIL %s idle_after got busy=%b cv=%b done=%b exp=0", tag,
                         busy_s[d], c_valid_s[d], done_s[d]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_chk++;
            if ({busy_s[d], in_ready_s[d], c_valid_s[d], done_s[d]} !== 4'b0 ||
                c_bus_s[d] !== 48'd0 || c_row_s[d] !== 2'd0) begin
                n_fail++;
                $display("FAIL reset d=%0d got busy=%b rdy=%b cv=%b done=%b bus=%h row=%0d exp=0", d,
                         busy_s[d], in_ready_s[d], c_valid_s[d], done_s[d], c_bus_s[d], c_row_s[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity(input bit stalls);
        for (int k = 0; k < 16; k++) gap_after[k] = 0;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) A_m[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++) B_m[k][j] = k * 3 + j + 1;
        if (stalls) begin
            gap_after[0] = 2;
            gap_after[1] = 2;
        end
        run_tile(0, 3, -1, 0, 1'b0, stalls ? "identity_stall" : "identity");
        for (int k = 0; k < 16; k++) gap_after[k] = 0;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 16; k++) begin
            gap_after[k] = 0;
            for (int i = 0; i < 3; i++) A_m[i][k] = -128;
            for (int j = 0; j < 3; j++) B_m[k][j] = -128;
        end
        run_tile(1, 4, -1, 0, 1'b0, "sat_clamp");
        run_tile(3, 4, -1, 0, 1'b0, "wrap_zero");
    endtask

    task automatic test_backpressure();
        fill_random();
        run_tile(2, 5, 1, 5, 1'b0, "backpressure");
    endtask

    task automatic test_zero_k();
        fill_random();
        run_tile(0, 0, -1, 0, 1'b1, "zero_k_desc");
        run_tile(2, 0, 1, 2, 1'b1, "zero_k_asc");
    endtask

    task automatic test_reset_mid_load();
        fill_random();
        @(negedge clk);
        start_s[0] = 1'b1; k_len_s[0] = 16'd4;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid_s[0] = 1'b1;
            a_s[0] = 24'($urandom);
            b_s[0] = 24'($urandom);
            if (b < 2) @(negedge clk);
        end
        n_chk++;
        if (in_ready_s[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid in_ready_before got=%b exp=1", in_ready_s[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy_s[0], in_ready_s[0], c_valid_s[0], done_s[0]} !== 4'b0 ||
            c_bus_s[0] !== 48'd0 || c_row_s[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid outputs got busy=%b rdy=%b cv=%b done=%b exp=0",
                     busy_s[0], in_ready_s[0], c_valid_s[0], done_s[0]);
        end
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            if (busy_s[0] || done_s[0] || c_valid_s[0]) begin
                n_fail++;
                $display("FAIL rst_mid idle got busy=%b done=%b cv=%b exp=0",
                         busy_s[0], done_s[0], c_valid_s[0]);
            end
        end
        run_tile(0, 4, -1, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int d, K;
        for (int t = 0; t < 8; t++) begin
            fill_random();
            d = t % 4;
            K = int'($urandom_range(1, 12));
            for (int k = 0; k < 16; k++) gap_after[k] = int'($urandom_range(0, 2));
            run_tile(d, K, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, "random");
        end
    endtask

    initial begin
        for (int d = 0; d < 4; d++) begin
            start_s[d] = 1'b0; in_valid_s[d] = 1'b0; c_ready_s[d] = 1'b0;
            k_len_s[d] = 16'd0; a_s[d] = 24'd0; b_s[d] = 24'd0;
        end
        test_reset();
        test_identity(1'b0);
        test_identity(1'b1);
        test_saturation();
        test_backpressure();
        test_zero_k();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
